// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter and bus multiplexer for the shared 8-bit data-memory bus.
// One registered one-hot grant; the owner's addr/wr/rd/wdata are steered to the slaves.
module data_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 16,
  parameter int HOLD_W      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_MASTERS-1:0]   mst_req,
  input  logic [NUM_MASTERS-1:0]   mst_lock,
  output logic [NUM_MASTERS-1:0]   mst_grant,
  input  logic [NUM_MASTERS*8-1:0] mst_addr,
  input  logic [NUM_MASTERS-1:0]   mst_wr,
  input  logic [NUM_MASTERS-1:0]   mst_rd,
  input  logic [NUM_MASTERS*8-1:0] mst_wdata,
  output logic [7:0]               slv_addr,
  output logic                     slv_wr,
  output logic                     slv_rd,
  output logic [7:0]               slv_wdata,
  output logic [2:0]               grant_idx,
  output logic                     bus_busy,
  output logic                     dbg_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [2:0]        LAST_IDX   = 3'(NUM_MASTERS - 1);

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [2:0]             r_idx;
  logic [2:0]             r_ptr;
  logic [HOLD_W-1:0]      r_hold;
  logic                   r_busy;

  logic                     w_owner_req;
  logic                     w_owner_lock;
  logic                     w_others;
  logic                     w_preempt;
  logic [NUM_MASTERS-1:0]   w_cand;
  logic [2*NUM_MASTERS-1:0] w_dbl;
  logic [NUM_MASTERS-1:0]   w_rot;
  logic                     w_found;
  logic [2:0]               w_off;
  logic [3:0]               w_sum;
  logic [2:0]               w_win;
  logic [NUM_MASTERS-1:0]   w_win_oh;
  logic [2:0]               w_ptr_nxt;

  // Owner attributes are taken through the one-hot grant, so no index decode is needed.
  assign w_owner_req  = |(mst_req & r_grant);
  assign w_owner_lock = |(mst_lock & r_grant);
  assign w_others     = |(mst_req & ~r_grant);

  assign w_preempt = (r_state == S_OWNED) && (MAX_HOLD != 0) && (r_hold == HOLD_LIMIT) &&
                     w_owner_req && w_others && !w_owner_lock;

  // A preempted owner sits out this search; otherwise a dropped owner has req=0 anyway.
  assign w_cand = w_preempt ? (mst_req & ~r_grant) : mst_req;

  // Rotate candidates so bit 0 is the RR pointer, pick the lowest set bit, rotate back.
  assign w_dbl = {w_cand, w_cand} >> r_ptr;
  assign w_rot = w_dbl[NUM_MASTERS-1:0];

  always_comb begin
    w_found = 1'b0;
    w_off   = 3'd0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = 3'(k);
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win     = (w_sum >= 4'(NUM_MASTERS)) ? 3'(w_sum - 4'(NUM_MASTERS)) : w_sum[2:0];
  assign w_win_oh  = NUM_MASTERS'(1) << w_win;
  assign w_ptr_nxt = (w_win == LAST_IDX) ? 3'd0 : w_win + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_idx   <= 3'd0;
      r_ptr   <= 3'd0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_OWNED;
            r_grant <= w_win_oh;
            r_idx   <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_OWNED: begin
          if (w_owner_req && !w_preempt) begin
            if (r_hold != HOLD_LIMIT) begin
              r_hold <= r_hold + 1'b1;
            end
          end else if (w_found) begin
            r_grant <= w_win_oh;
            r_idx   <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= '0;
          end else begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_idx   <= 3'd0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Grant is one-hot or zero, so OR-ing the gated buses selects exactly the owner.
  always_comb begin
    slv_addr  = 8'h00;
    slv_wdata = 8'h00;
    slv_wr    = 1'b0;
    slv_rd    = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      slv_addr  = slv_addr  | (mst_addr[8*k +: 8]  & {8{r_grant[k]}});
      slv_wdata = slv_wdata | (mst_wdata[8*k +: 8] & {8{r_grant[k]}});
      slv_wr    = slv_wr    | (mst_wr[k] & r_grant[k]);
      slv_rd    = slv_rd    | (mst_rd[k] & r_grant[k]);
    end
  end

  assign mst_grant = r_grant;
  assign grant_idx = r_idx;
  assign bus_busy  = r_busy;
  assign dbg_state = r_state;

endmodule
